// File: rtl/complete_multiplier_pkg.sv
// complete_multiplier_pkg: widths and mantissa helper shared by the multiplier files
package complete_multiplier_pkg;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 24;
    localparam int OP_W   = 32;
    localparam int ACC_W  = 64;
    localparam int RES_W  = 56;
    localparam int CT_W   = 5;

    function automatic logic [OP_W-1:0] mant_mag(input logic [OP_W-1:0] op);
        logic [OP_W-1:0] s;
        s = {{(OP_W-MANT_W){op[MANT_W-1]}}, op[MANT_W-1:0]};
        return s[OP_W-1] ? -s : s;
    endfunction
endpackage

// File: rtl/shift_add_mult.sv
// shift_add_mult: signed 24x24 mantissa multiply, one shift-and-add partial product per clock
module shift_add_mult
    import complete_multiplier_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op_a,
    input  logic [OP_W-1:0]  op_b,
    output logic [ACC_W-1:0] product,
    output logic             done
);
    logic [OP_W-1:0]  mag_a, mag_b, b_sh;
    logic [ACC_W-1:0] a_sh, addend, acc;
    logic [CT_W-1:0]  ct;
    logic             sign;

    assign mag_a   = mant_mag(op_a);
    assign mag_b   = mant_mag(op_b);
    assign sign    = op_a[MANT_W-1] ^ op_b[MANT_W-1];
    assign a_sh    = {{(ACC_W-OP_W){1'b0}}, mag_a} << ct;
    assign b_sh    = mag_b >> ct;
    assign addend  = a_sh & {ACC_W{b_sh[0]}};
    assign done    = b_sh == '0;
    assign product = sign ? -acc : acc;

    // accumulate one partial product per edge until the remaining multiplier bits are all zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ct  <= '0;
            acc <= '0;
        end else if (!done) begin
            acc <= acc + addend;
            ct  <= ct + 1'b1;
        end
    end
endmodule

// File: rtl/complete_multiplier.sv
// complete_multiplier: exponent add plus sequential mantissa multiply; COMPLETE_MULTIPLIER_TRISTATE_EN floats result while busy
module complete_multiplier
    import complete_multiplier_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  opA,
    input  logic [OP_W-1:0]  opB,
    output logic             exp_ok,
    output logic [RES_W-1:0] result
);
    logic [EXP_W:0]   exp_sum;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [ACC_W-1:0] product;
    logic             done, ovf, unused_hi;

    assign exp_a     = opA[OP_W-1:MANT_W];
    assign exp_b     = opB[OP_W-1:MANT_W];
    assign exp_sum   = {1'b0, exp_a} + {1'b0, exp_b};
    assign ovf       = (exp_a[EXP_W-1] == exp_b[EXP_W-1]) && (exp_sum[EXP_W-1] != exp_a[EXP_W-1]);
    assign exp_ok    = ~(exp_sum[EXP_W] | ovf);
    assign unused_hi = ^product[ACC_W-1:RES_W-EXP_W];

    shift_add_mult u_mult (
        .clk    (clk),
        .reset  (reset),
        .op_a   (opA),
        .op_b   (opB),
        .product(product),
        .done   (done)
    );

`ifdef COMPLETE_MULTIPLIER_TRISTATE_EN
    assign result = done ? {exp_sum[EXP_W-1:0], product[RES_W-EXP_W-1:0]} : {RES_W{1'bz}};
`else
    assign result = done ? {exp_sum[EXP_W-1:0], product[RES_W-EXP_W-1:0]} : '0;
`endif
endmodule

// File: tb/tb_complete_multiplier.sv
// tb_complete_multiplier: directed and random multiplies checked against a queued reference
module tb_complete_multiplier;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        exp_ok;
    logic [55:0] result;

    typedef struct {
        logic [55:0] res;
        logic        ok;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

`ifdef COMPLETE_MULTIPLIER_TRISTATE_EN
    localparam logic [55:0] IDLE = {56{1'bz}};
`else
    localparam logic [55:0] IDLE = 56'h0;
`endif

    complete_multiplier dut (
        .clk   (clk),
        .reset (reset),
        .opA   (opA),
        .opB   (opB),
        .exp_ok(exp_ok),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [55:0] obs, input logic [55:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, want);
            $error("%s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t e;
        logic signed [47:0] pa, pb, p;
        logic [23:0] mb;
        int ua, ub, sa, sbx;
        pa = {{24{a[23]}}, a[23:0]};
        pb = {{24{b[23]}}, b[23:0]};
        p  = pa * pb;
        ua = int'(a[31:24]);
        ub = int'(b[31:24]);
        sa = int'($signed(a[31:24]));
        sbx = int'($signed(b[31:24]));
        e.ok  = (ua + ub < 256) && (sa + sbx >= -128) && (sa + sbx <= 127);
        e.res = {8'(ua + ub), p};
        mb = b[23] ? -b[23:0] : b[23:0];
        e.lat = 0;
        for (int i = 0; i < 24; i++) if (mb[i]) e.lat = i + 1;
        e.tag = tag;
        return e;
    endfunction

    // Drive operands, reset, optionally abort after abort_at edges, then check latency and result.
    task automatic run(input logic [31:0] a, input logic [31:0] b, input exp_t e, input int abort_at);
        exp_t got;
        @(negedge clk);
        opA = a;
        opB = b;
        reset = 1'b1;
        sb.push_back(e);
        #1;
        chk({e.tag, "_rst_result"}, result, e.lat == 0 ? e.res : IDLE);
        chk({e.tag, "_rst_expok"}, {55'h0, exp_ok}, {55'h0, e.ok});
        #1 reset = 1'b0;
        if (abort_at > 0) begin
            for (int k = 0; k < abort_at; k++) begin
                @(posedge clk);
                #1;
            end
            chk({e.tag, "_pre_abort"}, result, IDLE);
            reset = 1'b1;
            #1;
            chk({e.tag, "_abort_idle"}, result, IDLE);
            #1 reset = 1'b0;
        end
        for (int k = 1; k <= e.lat; k++) begin
            @(posedge clk);
            #1;
            if (k < e.lat) chk({e.tag, "_busy"}, result, IDLE);
        end
        got = sb.pop_front();
        chk({got.tag, "_result"}, result, got.res);
        chk({got.tag, "_expok"}, {55'h0, exp_ok}, {55'h0, got.ok});
        @(posedge clk);
        #1;
        chk({got.tag, "_hold"}, result, got.res);
    endtask

    initial begin
        exp_t e;
        logic [31:0] a, b;
        e = '{res: 56'h02000000000001, ok: 1'b1, lat: 1, tag: "one_x_one"};
        run(32'h01000001, 32'h01000001, e, 0);
        e = '{res: 56'hC0FFFFFFFFFFFE, ok: 1'b0, lat: 2, tag: "one_x_m2"};
        run(32'h41000001, 32'h7FFFFFFE, e, 0);
        e = '{res: 56'h00400000000000, ok: 1'b1, lat: 24, tag: "min_x_min"};
        run(32'h00800000, 32'h00800000, e, 0);
        e = '{res: 56'h00000000000000, ok: 1'b0, lat: 0, tag: "b_zero"};
        run(32'hFF000005, 32'h01000000, e, 0);
        e = '{res: 56'h00FFFFFFFFFFF7, ok: 1'b1, lat: 2, tag: "three_x_m3"};
        run(32'h00000003, 32'h00FFFFFD, e, 0);
        e = '{res: 56'h00400000000000, ok: 1'b1, lat: 24, tag: "abort"};
        run(32'h00800000, 32'h00800000, e, 1);
        e = model(32'h10000000, 32'h20FFFFFF, "a_zero_neg");
        run(32'h10000000, 32'h20FFFFFF, e, 0);
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            e = model(a, b, "rand");
            run(a, b, e, 0);
        end
        chk("sb_empty", 56'(sb.size()), 56'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
